// File: rtl/alu_arb.sv
// Round-robin arbiter/sequencer sharing one combinational saturating ALU between two
// requesters: grant, one issue cycle, then hold the captured response until acknowledged.
module alu_arb #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [2:0]    func0,
  input  logic [2:0]    func1,
  input  logic [DW-1:0] src0_0,
  input  logic [DW-1:0] src1_0,
  input  logic [DW-1:0] src0_1,
  input  logic [DW-1:0] src1_1,
  input  logic [3:0]    shamt0,
  input  logic [3:0]    shamt1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  input  logic          ack0,
  input  logic          ack1,
  output logic [DW-1:0] res,
  output logic          res_ov,
  output logic          res_zr,
  output logic          res_neg,
  output logic [2:0]    alu_func,
  output logic [DW-1:0] alu_src0,
  output logic [DW-1:0] alu_src1,
  output logic [3:0]    alu_shamt,
  input  logic [DW-1:0] alu_dst,
  input  logic          alu_ov,
  input  logic          alu_zr,
  input  logic          alu_neg
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic          prio;
  logic          owner;
  logic          sel;
  logic          grant;
  logic          owner_ack;
  logic [2:0]    op_func;
  logic [DW-1:0] op_src0;
  logic [DW-1:0] op_src1;
  logic [3:0]    op_shamt;

  // With both requesting, prio breaks the tie; otherwise the lone requester wins.
  always_comb begin
    sel       = (req0 && req1) ? prio : req1;
    grant     = (state == IDLE) && (req0 || req1) && !rst;
    owner_ack = owner ? ack1 : ack0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0 || req1) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (owner_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0  = grant && !sel;
    gnt1  = grant && sel;
    done0 = (state == RESP) && !owner && !rst;
    done1 = (state == RESP) && owner && !rst;
  end

  // Operand capture on grant, result capture at the end of the single issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      op_func  <= '0;
      op_src0  <= '0;
      op_src1  <= '0;
      op_shamt <= '0;
      res      <= '0;
      res_ov   <= 1'b0;
      res_zr   <= 1'b0;
      res_neg  <= 1'b0;
    end else begin
      if (grant) begin
        owner    <= sel;
        prio     <= !sel;
        op_func  <= sel ? func1  : func0;
        op_src0  <= sel ? src0_1 : src0_0;
        op_src1  <= sel ? src1_1 : src1_0;
        op_shamt <= sel ? shamt1 : shamt0;
      end
      if (state == ISSUE) begin
        res     <= alu_dst;
        res_ov  <= alu_ov;
        res_zr  <= alu_zr;
        res_neg <= alu_neg;
      end
    end
  end

  assign alu_func  = op_func;
  assign alu_src0  = op_src0;
  assign alu_src1  = op_src1;
  assign alu_shamt = op_shamt;

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter and sequencer that shares the single saturating 16-bit ALU between two requesters (e.g. the main pipeline's EX stage and a coprocessor/DMA-style engine). It grants one requester at a time by round-robin and latches that requester's operands. It drives the ALU's combinational inputs for one issue cycle and captures the ALU result and flags. It then holds the response until the requester acknowledges it.

## Interface
Parameters:
- DW, 16, datapath width; must match the ALU (the 4-bit shamt assumes DW=16)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high with stable operands until granted
- func0 / func1  in  3  ALU function code; passed through unmodified (000 ADD, 001 SUB, 010 AND, 011 NOR, 100 SLL, 101 SRL, 110 SRA, 111 passed as-is)
- src0_0, src1_0 / src0_1, src1_1  in  DW  operands of requester 0 / 1
- shamt0 / shamt1  in  4  shift amount
- gnt0 / gnt1  out  1  combinational; operands accepted at this clock edge
- done0 / done1  out  1  result valid for that requester, held until acked
- ack0 / ack1  in  1  response consumed
- res  out  DW  captured ALU result (shared by both requesters; qualified by doneX)
- res_ov, res_zr, res_neg  out  1  captured ALU flags
- alu_func  out  3  to ALU func
- alu_src0, alu_src1  out  DW  to ALU operands
- alu_shamt  out  4  to ALU shamt
- alu_dst  in  DW  ALU combinational result (not the flopped copy)
- alu_ov, alu_zr, alu_neg  in  1  ALU combinational flags

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE
  - Select a requester: if only one of req0/req1 is high, select it.
  - If both are high, select the one the priority pointer `prio` names (prio=0 → port 0).
  - Assert gnt of the selected port only. Capture its func/src0/src1/shamt into the operand regs, record `owner`, and go to ISSUE.
  - Set `prio` to the non-owner on every grant.
  - No request: stay in IDLE, no gnt.
- ISSUE
  - alu_* outputs are driven from the operand regs.
  - At the clock edge, capture alu_dst/ov/zr/neg into res/res_*, then go to RESP.
  - No gnt is issued.
- RESP
  - Assert done[owner] only; res/res_* are stable.
  - When ack[owner] is sampled high, go to IDLE.
  - ack of the non-owner is ignored.
  - New requests wait; there is no grant in RESP.
- alu_* outputs always reflect the operand regs; they change only on a grant. Outside ISSUE their values carry no meaning.
- res/res_* hold their last captured value until the next ISSUE.
- func is not decoded; saturation and flag semantics come entirely from the ALU.
- A requester dropping req before gnt: no grant, no state change.
- ackX high while doneX low: ignored.

## Timing
- Reset (rst sampled high): state=IDLE, prio=0, owner=0, operand regs=0, res=0, res_ov=0, res_zr=0, res_neg=0.
  - Therefore alu_func=0, alu_src0/src1=0, alu_shamt=0, gnt0/1=0 during reset, done0/1=0.
- Reset overrides any state, including mid-ISSUE and mid-RESP. An in-flight op is discarded with no done pulse.
- Latency for grant at edge N (gnt high in cycle N):
  - cycle N+1 is ISSUE;
  - doneX is high from cycle N+2;
  - with ack in cycle N+2, IDLE is in N+3 and the next gnt can occur in N+3.
- Maximum throughput: one operation per 3 cycles.
- gnt depends combinationally on req, state and prio only; it does not depend on ack.
- Simultaneous req0 and req1 held continuously: grants alternate 0,1,0,1… starting from port 0 after reset.

## Test plan
- Single ADD on port 0: src1=0x1234, src0=0x0001, func=000, ack tied high.
  - gnt0 one cycle, done0 two cycles later, res=0x1235, zr=0, ov=0, neg=0.
  - gnt1 and done1 never assert.
- Saturating SUB on port 1: src1=0x8000, src0=0x0001, func=001.
  - res=0x8000, res_ov=1, res_neg=1, done1 only.
- Contention: req0 and req1 both held high from reset, each with distinct ADD operands, ack held high.
  - Grant order 0,1,0,1 at 3-cycle spacing.
  - Each doneX carries that port's own sum.
- Delayed ack on port 0 (SLL, src1=0x0001, shamt=4):
  - done0 and res=0x0010 stay stable for 5 cycles until ack0;
  - req1 asserted meanwhile receives no gnt until the cycle after ack0 is sampled.
- Reset mid-operation: assert rst in the ISSUE cycle of a port-1 AND.
  - Next cycle all outputs are at reset values and no done1 pulse occurs.
  - A subsequent req1 completes normally.
- Spurious signals: ack1 pulsed while port 0 owns RESP, and req0 pulsed low before a grant.
  - No state change, no premature IDLE, no grant issued.
